// File: rtl/text_column_renderer.sv
// text_column_renderer
// Renders a 14x6 character screen into 48-bit pixel columns for the Nokia
// 5110 screen controller write port. The host fills an 84-entry character
// buffer, then pulses refresh. All 84 columns are then swept through a
// 5x8 font ROM, with one column write per column.
// Ports:
//   clk_main             system clock
//   rst_n                synchronous active-low reset
//   char_wr_en           host character write strobe
//   char_col/char_row    target cell (col 0..13, row 0..5)
//   char_code            ASCII code to store
//   refresh              start a frame render (sampled only when idle)
//   busy                 high while clearing or rendering
//   frame_done           one-cycle pulse after the last column write
//   address/data/wr_en   column write port towards the screen controller
module text_column_renderer #(
  parameter int NB_COLUMNS   = 84,
  parameter int NB_TEXT_ROWS = 6,
  parameter int CHAR_WIDTH   = 6
) (
  input  logic                      clk_main,
  input  logic                      rst_n,
  input  logic                      char_wr_en,
  input  logic [3:0]                char_col,
  input  logic [2:0]                char_row,
  input  logic [6:0]                char_code,
  input  logic                      refresh,
  output logic                      busy,
  output logic                      frame_done,
  output logic [6:0]                address,
  output logic [8*NB_TEXT_ROWS-1:0] data,
  output logic                      wr_en
);

  localparam int NB_CHAR_COLS = NB_COLUMNS / CHAR_WIDTH;
  localparam int NB_CELLS     = NB_CHAR_COLS * NB_TEXT_ROWS;

  localparam logic [2:0] ST_CLEAR = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_EMIT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Glyph packed as {byte0, byte1, byte2, byte3, byte4}; bit 0 of a byte is the top pixel.
  // Codes without an entry (controls, space, DEL) are blank.
  function automatic logic [39:0] font_glyph(input logic [6:0] code);
    logic [39:0] g;
    g = 40'h0000000000;
    case (code)
      7'h21: g = 40'h00005F0000; 7'h22: g = 40'h0007000700; 7'h23: g = 40'h147F147F14;
      7'h24: g = 40'h242A7F2A12; 7'h25: g = 40'h2313086462; 7'h26: g = 40'h3649552250;
      7'h27: g = 40'h0005030000; 7'h28: g = 40'h001C224100; 7'h29: g = 40'h0041221C00;
      7'h2A: g = 40'h14083E0814; 7'h2B: g = 40'h08083E0808; 7'h2C: g = 40'h0050300000;
      7'h2D: g = 40'h0808080808; 7'h2E: g = 40'h0060600000; 7'h2F: g = 40'h2010080402;
      7'h30: g = 40'h3E5149453E; 7'h31: g = 40'h00427F4000; 7'h32: g = 40'h4261514946;
      7'h33: g = 40'h2141454B31; 7'h34: g = 40'h1814127F10; 7'h35: g = 40'h2745454539;
      7'h36: g = 40'h3C4A494930; 7'h37: g = 40'h0171090503; 7'h38: g = 40'h3649494936;
      7'h39: g = 40'h064949291E; 7'h3A: g = 40'h0036360000; 7'h3B: g = 40'h0056360000;
      7'h3C: g = 40'h0814224100; 7'h3D: g = 40'h1414141414; 7'h3E: g = 40'h0041221408;
      7'h3F: g = 40'h0201510906; 7'h40: g = 40'h324979413E; 7'h41: g = 40'h7E1111117E;
      7'h42: g = 40'h7F49494936; 7'h43: g = 40'h3E41414122; 7'h44: g = 40'h7F4141221C;
      7'h45: g = 40'h7F49494941; 7'h46: g = 40'h7F09090901; 7'h47: g = 40'h3E4149497A;
      7'h48: g = 40'h7F0808087F; 7'h49: g = 40'h00417F4100; 7'h4A: g = 40'h2040413F01;
      7'h4B: g = 40'h7F08142241; 7'h4C: g = 40'h7F40404040; 7'h4D: g = 40'h7F020C027F;
      7'h4E: g = 40'h7F0408107F; 7'h4F: g = 40'h3E4141413E; 7'h50: g = 40'h7F09090906;
      7'h51: g = 40'h3E4151215E; 7'h52: g = 40'h7F09192946; 7'h53: g = 40'h4649494931;
      7'h54: g = 40'h01017F0101; 7'h55: g = 40'h3F4040403F; 7'h56: g = 40'h1F2040201F;
      7'h57: g = 40'h3F4038403F; 7'h58: g = 40'h6314081463; 7'h59: g = 40'h0708700807;
      7'h5A: g = 40'h6151494543; 7'h5B: g = 40'h007F414100; 7'h5C: g = 40'h0204081020;
      7'h5D: g = 40'h0041417F00; 7'h5E: g = 40'h0402010204; 7'h5F: g = 40'h4040404040;
      7'h60: g = 40'h0001020400; 7'h61: g = 40'h2054545478; 7'h62: g = 40'h7F48444438;
      7'h63: g = 40'h3844444420; 7'h64: g = 40'h384444487F; 7'h65: g = 40'h3854545418;
      7'h66: g = 40'h087E090102; 7'h67: g = 40'h0C5252523E; 7'h68: g = 40'h7F08040478;
      7'h69: g = 40'h00447D4000; 7'h6A: g = 40'h2040443D00; 7'h6B: g = 40'h7F10284400;
      7'h6C: g = 40'h00417F4000; 7'h6D: g = 40'h7C04180478; 7'h6E: g = 40'h7C08040478;
      7'h6F: g = 40'h3844444438; 7'h70: g = 40'h7C14141408; 7'h71: g = 40'h081414187C;
      7'h72: g = 40'h7C08040408; 7'h73: g = 40'h4854545420; 7'h74: g = 40'h043F444020;
      7'h75: g = 40'h3C4040207C; 7'h76: g = 40'h1C2040201C; 7'h77: g = 40'h3C4030403C;
      7'h78: g = 40'h4428102844; 7'h79: g = 40'h0C5050503C; 7'h7A: g = 40'h4464544C44;
      7'h7B: g = 40'h0008364100; 7'h7C: g = 40'h00007F0000; 7'h7D: g = 40'h0041360800;
      7'h7E: g = 40'h1008081008;
      default: g = 40'h0000000000;
    endcase
    return g;
  endfunction

  // One glyph column; sub-column 5 is the blank spacer between cells.
  function automatic logic [7:0] glyph_byte(input logic [6:0] code, input logic [2:0] sub);
    logic [39:0] g;
    logic [7:0]  b;
    g = font_glyph(code);
    case (sub)
      3'd0:    b = g[39:32];
      3'd1:    b = g[31:24];
      3'd2:    b = g[23:16];
      3'd3:    b = g[15:8];
      3'd4:    b = g[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic [2:0]  state_r, state_nxt_s;
  logic [6:0]  clr_idx_r;
  logic [6:0]  col_r;
  logic [3:0]  cell_r;
  logic [2:0]  sub_r;
  logic [2:0]  row_r;
  logic [6:0]  char_buf_r [0:NB_CELLS-1];
  logic [6:0]  char_q_r;
  logic [2:0]  q_row_r;
  logic        q_valid_r;
  logic [8*NB_TEXT_ROWS-1:0] col_acc_r;
  logic        busy_r, frame_done_r, wr_en_r;
  logic [6:0]  address_r;
  logic [8*NB_TEXT_ROWS-1:0] data_r;
  logic        buf_we_s;
  logic [6:0]  buf_waddr_s, buf_wdata_s, rd_idx_s;
  logic [7:0]  rom_byte_s;

  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign wr_en      = wr_en_r;
  assign address    = address_r;
  assign data       = data_r;

  // Frame sequencer next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: if (clr_idx_r == 7'(NB_CELLS - 1)) state_nxt_s = ST_IDLE; else state_nxt_s = ST_CLEAR;
      ST_IDLE:  if (refresh) state_nxt_s = ST_FETCH; else state_nxt_s = ST_IDLE;
      ST_FETCH: if (row_r == 3'(NB_TEXT_ROWS - 1)) state_nxt_s = ST_DRAIN; else state_nxt_s = ST_FETCH;
      ST_DRAIN: state_nxt_s = ST_EMIT;
      ST_EMIT:  if (col_r == 7'(NB_COLUMNS - 1)) state_nxt_s = ST_DONE; else state_nxt_s = ST_FETCH;
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_CLEAR;
    endcase
  end

  // Buffer write port: CLEAR owns it, otherwise in-range host writes.
  always_comb begin
    buf_we_s    = 1'b0;
    buf_waddr_s = 7'd0;
    buf_wdata_s = 7'd0;
    if (state_r == ST_CLEAR) begin
      buf_we_s    = 1'b1;
      buf_waddr_s = clr_idx_r;
      buf_wdata_s = 7'h20;
    end else if (char_wr_en && (char_col < 4'(NB_CHAR_COLS)) && (char_row < 3'(NB_TEXT_ROWS))) begin
      buf_we_s    = 1'b1;
      buf_waddr_s = 7'(char_row) * 7'(NB_CHAR_COLS) + 7'(char_col);
      buf_wdata_s = char_code;
    end else begin
      buf_we_s    = 1'b0;
    end
  end

  // Fetch address and font ROM lookup of the previously read character.
  always_comb begin
    rd_idx_s   = 7'(row_r) * 7'(NB_CHAR_COLS) + 7'(cell_r);
    rom_byte_s = glyph_byte(char_q_r, sub_r);
  end

  // Character buffer: synchronous read-before-write, no writes during reset.
  always_ff @(posedge clk_main) begin
    if (rst_n && buf_we_s) begin
      char_buf_r[buf_waddr_s] <= buf_wdata_s;
    end
    char_q_r <= char_buf_r[rd_idx_s];
  end

  // Sequencer state, column counters, glyph accumulator and output registers.
  always_ff @(posedge clk_main) begin
    if (!rst_n) begin
      state_r      <= ST_CLEAR;
      clr_idx_r    <= 7'd0;
      col_r        <= 7'd0;
      cell_r       <= 4'd0;
      sub_r        <= 3'd0;
      row_r        <= 3'd0;
      q_row_r      <= 3'd0;
      q_valid_r    <= 1'b0;
      col_acc_r    <= '0;
      busy_r       <= 1'b1;
      frame_done_r <= 1'b0;
      wr_en_r      <= 1'b0;
      address_r    <= 7'd0;
      data_r       <= '0;
    end else begin
      state_r      <= state_nxt_s;
      wr_en_r      <= 1'b0;
      frame_done_r <= 1'b0;
      // DONE is not reported busy so busy drops together with the frame_done pulse.
      busy_r       <= (state_r == ST_CLEAR) || (state_r == ST_FETCH) ||
                      (state_r == ST_DRAIN) || (state_r == ST_EMIT);
      // The buffer read of the previous cycle now goes through the ROM into its row slot.
      q_row_r      <= row_r;
      q_valid_r    <= (state_r == ST_FETCH);
      if (q_valid_r) begin
        col_acc_r[{q_row_r, 3'b000} +: 8] <= rom_byte_s;
      end
      case (state_r)
        ST_CLEAR: clr_idx_r <= clr_idx_r + 7'd1;
        ST_IDLE: begin
          col_r  <= 7'd0;
          cell_r <= 4'd0;
          sub_r  <= 3'd0;
          row_r  <= 3'd0;
        end
        ST_FETCH: begin
          if (row_r == 3'(NB_TEXT_ROWS - 1)) row_r <= 3'd0;
          else                               row_r <= row_r + 3'd1;
        end
        ST_EMIT: begin
          address_r <= col_r;
          data_r    <= col_acc_r;
          wr_en_r   <= 1'b1;
          col_r     <= col_r + 7'd1;
          if (sub_r == 3'(CHAR_WIDTH - 1)) begin
            sub_r  <= 3'd0;
            cell_r <= cell_r + 4'd1;
          end else begin
            sub_r  <= sub_r + 3'd1;
          end
        end
        ST_DONE:  frame_done_r <= 1'b1;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_column_renderer.sv
module tb_text_column_renderer;

  logic        clk_main = 1'b0;
  logic        rst_n = 1'b0;
  logic        char_wr_en = 1'b0;
  logic [3:0]  char_col = 4'd0;
  logic [2:0]  char_row = 3'd0;
  logic [6:0]  char_code = 7'd0;
  logic        refresh = 1'b0;
  logic        busy, frame_done, wr_en;
  logic [6:0]  address;
  logic [47:0] data;

  text_column_renderer dut (
    .clk_main(clk_main), .rst_n(rst_n), .char_wr_en(char_wr_en), .char_col(char_col),
    .char_row(char_row), .char_code(char_code), .refresh(refresh), .busy(busy),
    .frame_done(frame_done), .address(address), .data(data), .wr_en(wr_en)
  );

  always #5 clk_main = ~clk_main;

  int cyc = 0;
  always @(posedge clk_main) cyc <= cyc + 1;

  typedef struct {
    logic [6:0]  addr;
    logic [47:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [3:0] col;
    logic [2:0] row;
    logic [6:0] code;
    bit         accept;
    int         probe_col;
    int         probe_row;
    logic [7:0] probe_byte;
  } wr_vec_t;

  exp_t        sb_q[$];
  logic [6:0]  shadow [0:83];
  logic [47:0] seen_data [0:83];
  int          errors = 0;
  int          checks = 0;
  int          strobe_cnt = 0;
  int          done_cnt = 0;
  bit          prev_wr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference glyphs for the characters used here; bit 0 = top pixel.
  function automatic logic [7:0] tb_glyph(input logic [6:0] code, input int sub);
    logic [7:0] g [5];
    case (code)
      7'h41:   g = '{8'h7E, 8'h11, 8'h11, 8'h11, 8'h7E};
      7'h48:   g = '{8'h7F, 8'h08, 8'h08, 8'h08, 8'h7F};
      7'h58:   g = '{8'h63, 8'h14, 8'h08, 8'h14, 8'h63};
      default: g = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    endcase
    if (sub > 4) return 8'h00;
    return g[sub];
  endfunction

  // Output monitor: pops the scoreboard on every column strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_main);
      if (wr_en) begin
        strobe_cnt++;
        check("wr_en_gap", {63'd0, prev_wr}, 64'd0);
        seen_data[address] = data;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wr: got address %0d expected no strobe (cycle %0d)", address, cyc);
        end else begin
          e = sb_q.pop_front();
          check("col_address", {57'd0, address}, {57'd0, e.addr});
          check("col_data", {16'd0, data}, {16'd0, e.data});
          check("col_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (frame_done) done_cnt++;
      prev_wr = wr_en;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_main);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic write_char(input logic [3:0] c, input logic [2:0] r, input logic [6:0] code);
    char_wr_en = 1'b1;
    char_col   = c;
    char_row   = r;
    char_code  = code;
    step();
    char_wr_en = 1'b0;
  endtask

  task automatic blank_shadow();
    for (int i = 0; i < 84; i++) shadow[i] = 7'h20;
  endtask

  task automatic push_frame(input int n);
    exp_t e;
    for (int k = 0; k < 84; k++) begin
      e.addr = 7'(k);
      e.data = 48'd0;
      for (int r = 0; r < 6; r++) e.data[8*r +: 8] = tb_glyph(shadow[r*14 + k/6], k % 6);
      e.cyc = n + 8 + 8*k;
      sb_q.push_back(e);
    end
  endtask

  task automatic start_frame(output int n);
    refresh = 1'b1;
    n = cyc + 1;
    step();
    refresh = 1'b0;
    step();
    check("busy_rise", {63'd0, busy}, 64'd1);
  endtask

  task automatic finish_frame(input int n);
    int d0;
    d0 = done_cnt;
    wait_until(n + 672);
    check("busy_last_col", {63'd0, busy}, 64'd1);
    check("frame_done_early", {63'd0, frame_done}, 64'd0);
    step();
    check("frame_done_pulse", {63'd0, frame_done}, 64'd1);
    check("busy_fall", {63'd0, busy}, 64'd0);
    check("queue_drained", 64'(sb_q.size()), 64'd0);
    step();
    check("frame_done_once", 64'(done_cnt - d0), 64'd1);
  endtask

  // Release reset and run the 84-cycle clear, trying a write in the middle of it.
  task automatic release_and_clear();
    int r;
    rst_n = 1'b1;
    r = cyc;
    wait_until(r + 9);
    write_char(4'd0, 3'd0, 7'h41);
    wait_until(r + 84);
    check("busy_clear_last", {63'd0, busy}, 64'd1);
    step();
    check("busy_after_clear", {63'd0, busy}, 64'd0);
    blank_shadow();
  endtask

  initial begin
    wr_vec_t vecs [6];
    int n, n2, s0;

    vecs[0] = '{4'd0,  3'd0, 7'h41, 1'b1, 0,  0, 8'h7E};
    vecs[1] = '{4'd13, 3'd5, 7'h7F, 1'b1, 78, 5, 8'h00};
    vecs[2] = '{4'd13, 3'd2, 7'h48, 1'b1, 78, 2, 8'h7F};
    vecs[3] = '{4'd14, 3'd0, 7'h58, 1'b0, 0,  1, 8'h00};
    vecs[4] = '{4'd5,  3'd6, 7'h58, 1'b0, 30, 0, 8'h00};
    vecs[5] = '{4'd2,  3'd1, 7'h58, 1'b1, 12, 1, 8'h63};

    // Reset values.
    step(); step(); step();
    check("rst_busy", {63'd0, busy}, 64'd1);
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_frame_done", {63'd0, frame_done}, 64'd0);
    check("rst_address", {57'd0, address}, 64'd0);
    check("rst_data", {16'd0, data}, 64'd0);

    release_and_clear();

    // Blank frame; the write attempted during CLEAR must not show.
    s0 = strobe_cnt;
    start_frame(n);
    push_frame(n);
    finish_frame(n);
    check("blank_strobes", 64'(strobe_cnt - s0), 64'd84);

    // Table of host writes, then one frame with per-write probes.
    for (int i = 0; i < 6; i++) begin
      write_char(vecs[i].col, vecs[i].row, vecs[i].code);
      if (vecs[i].accept) shadow[32'(vecs[i].row)*14 + 32'(vecs[i].col)] = vecs[i].code;
    end
    start_frame(n);
    push_frame(n);
    finish_frame(n);
    for (int i = 0; i < 6; i++)
      check("probe", {56'd0, seen_data[vecs[i].probe_col][8*vecs[i].probe_row +: 8]},
            {56'd0, vecs[i].probe_byte});

    // Writes while rendering plus an ignored refresh at N+100.
    s0 = strobe_cnt;
    shadow[2] = 7'h58;
    start_frame(n);
    push_frame(n);
    wait_until(n + 49);
    write_char(4'd2, 3'd0, 7'h58);
    wait_until(n + 59);
    write_char(4'd0, 3'd0, 7'h58);
    wait_until(n + 99);
    refresh = 1'b1;
    step();
    refresh = 1'b0;
    finish_frame(n);
    shadow[0] = 7'h58;
    step(); step();
    check("midframe_strobes", 64'(strobe_cnt - s0), 64'd84);

    // Frame aborted by reset at N+300; earlier columns still checked.
    start_frame(n);
    push_frame(n);
    wait_until(n + 299);
    rst_n = 1'b0;
    sb_q.delete();
    s0 = strobe_cnt;
    step();
    check("abort_wr_en", {63'd0, wr_en}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd1);
    check("abort_address", {57'd0, address}, 64'd0);
    step(); step();
    release_and_clear();
    check("abort_no_strobes", 64'(strobe_cnt - s0), 64'd0);

    // Blank frame after re-clear, with refresh held across DONE.
    start_frame(n);
    push_frame(n);
    wait_until(n + 669);
    refresh = 1'b1;
    finish_frame(n);
    n2 = n + 674;
    push_frame(n2);
    step();
    refresh = 1'b0;
    check("held_refresh_busy", {63'd0, busy}, 64'd1);
    finish_frame(n2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
